// File: rtl/cby_cfg_param.sv
// cby_cfg_param: parametrised Y-direction connection block.
//
// Vertical channel tracks pass straight through in both directions. NUM_IPIN grid input pins
// are driven by track multiplexers whose selections are loaded serially through the
// configuration chain (ccff_head -> ccff_tail) into a shadow register and copied into the
// active register on ccff_commit. Routing therefore stays live while a new frame shifts in.
//
// Ports:
//   prog_clk         - configuration clock (only clock)
//   pReset           - asynchronous active-high reset
//   chany_bottom_in  - tracks entering from below
//   chany_top_in     - tracks entering from above
//   ccff_head        - serial configuration data in
//   ccff_en          - shift enable for the shadow chain
//   ccff_commit      - copy shadow into active
//   chany_bottom_out - equals chany_top_in
//   chany_top_out    - equals chany_bottom_in
//   ipin_out         - grid pin drives
//   ccff_tail        - serial data out (last shadow bit)
//   frame_done       - one-cycle pulse after the last shift of a frame
//   cfg_valid        - sticky, set by the first commit after reset
module cby_cfg_param #(
  parameter int unsigned CHAN_WIDTH   = 20,
  parameter int unsigned NUM_IPIN     = 7,
  parameter int unsigned MUX_SIZE     = 8,
  parameter int unsigned TRACK_STRIDE = 6,
  parameter int unsigned PIN_OFFSET   = 1
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  ccff_tail,
  output logic                  frame_done,
  output logic                  cfg_valid
);

  localparam int unsigned SEL_W = $clog2(MUX_SIZE);
  localparam int unsigned F     = SEL_W + 1;
  localparam int unsigned L     = NUM_IPIN * F;
  localparam int unsigned CNT_W = (L > 1) ? $clog2(L) : 1;
  // Select codes span a power of two; codes at or above MUX_SIZE read a tied-off slot.
  localparam int unsigned NSLOT = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  logic [L-1:0]     sh_q, sh_d;
  logic [L-1:0]     act_q, act_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             frame_last;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  assign frame_last = (bit_cnt_q == CNT_LAST);

  always_comb begin
    sh_d         = sh_q;
    act_d        = act_q;
    bit_cnt_d    = bit_cnt_q;
    cfg_valid_d  = cfg_valid_q;
    frame_done_d = 1'b0;

    if (ccff_en) begin
      sh_d = {sh_q[L-2:0], ccff_head};
    end

    // Commit captures the pre-edge shadow and restarts the frame count; it also
    // suppresses a frame_done that a simultaneous final shift would have raised.
    if (ccff_commit) begin
      act_d       = sh_q;
      cfg_valid_d = 1'b1;
      bit_cnt_d   = '0;
    end else if (ccff_en) begin
      bit_cnt_d    = frame_last ? '0 : bit_cnt_q + CNT_W'(1);
      frame_done_d = frame_last;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sh_q         <= '0;
      act_q        <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      cfg_valid_q  <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      act_q        <= act_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      cfg_valid_q  <= cfg_valid_d;
    end
  end

  assign ccff_tail  = sh_q[L-1];
  assign frame_done = frame_done_q;
  assign cfg_valid  = cfg_valid_q;

  // Pin muxes: even code 2m takes bottom track t, odd code 2m+1 takes top track t, with
  // t = (p*PIN_OFFSET + m*TRACK_STRIDE) mod CHAN_WIDTH fixed at elaboration.
  for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
    logic [NSLOT-1:0] cand;
    logic [SEL_W-1:0] sel;
    logic             en;

    assign en  = act_q[p*F];
    assign sel = act_q[p*F+1 +: SEL_W];

    for (genvar m = 0; m < NSLOT / 2; m++) begin : g_pair
      if (2 * m < MUX_SIZE) begin : g_used
        localparam int unsigned T = (p * PIN_OFFSET + m * TRACK_STRIDE) % CHAN_WIDTH;
        assign cand[2*m]   = chany_bottom_in[T];
        assign cand[2*m+1] = chany_top_in[T];
      end else begin : g_unused
        assign cand[2*m +: 2] = 2'b00;
      end
    end

    assign ipin_out[p] = en & cand[sel];
  end

endmodule

// File: tb/tb_cby_cfg_param.sv
module tb_cby_cfg_param;

  localparam int CW  = 20;
  localparam int NP  = 7;
  localparam int MS  = 8;
  localparam int MS6 = 6;
  localparam int TS  = 6;
  localparam int PO  = 1;
  localparam int SW  = 3;
  localparam int F   = SW + 1;
  localparam int L   = NP * F;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic [CW-1:0] bot_in, top_in;
  logic          head, en, commit;

  logic [CW-1:0] bot_out, top_out, bot_out6, top_out6;
  logic [NP-1:0] ipin, ipin6;
  logic          tail, fd, cv, tail6, fd6, cv6;

  always #5 prog_clk = ~prog_clk;

  cby_cfg_param #(
    .CHAN_WIDTH(CW), .NUM_IPIN(NP), .MUX_SIZE(MS), .TRACK_STRIDE(TS), .PIN_OFFSET(PO)
  ) dut (
    .prog_clk(prog_clk), .pReset(pReset),
    .chany_bottom_in(bot_in), .chany_top_in(top_in),
    .ccff_head(head), .ccff_en(en), .ccff_commit(commit),
    .chany_bottom_out(bot_out), .chany_top_out(top_out),
    .ipin_out(ipin), .ccff_tail(tail), .frame_done(fd), .cfg_valid(cv)
  );

  cby_cfg_param #(
    .CHAN_WIDTH(CW), .NUM_IPIN(NP), .MUX_SIZE(MS6), .TRACK_STRIDE(TS), .PIN_OFFSET(PO)
  ) dut6 (
    .prog_clk(prog_clk), .pReset(pReset),
    .chany_bottom_in(bot_in), .chany_top_in(top_in),
    .ccff_head(head), .ccff_en(en), .ccff_commit(commit),
    .chany_bottom_out(bot_out6), .chany_top_out(top_out6),
    .ipin_out(ipin6), .ccff_tail(tail6), .frame_done(fd6), .cfg_valid(cv6)
  );

  // Reference model: shadow as a queue (front = newest bit), active config per pin.
  bit msh[$];
  bit aen[NP];
  int asel[NP];
  int mcnt;
  bit mfd, mcv;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_pin(input int p, input int ms);
    int t;
    if (!aen[p] || asel[p] >= ms) return 1'b0;
    t = (p * PO + (asel[p] / 2) * TS) % CW;
    return (asel[p] % 2 == 1) ? top_in[t] : bot_in[t];
  endfunction

  function automatic logic [NP-1:0] exp_ipin(input int ms);
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = exp_pin(p, ms);
    return v;
  endfunction

  task automatic model_reset();
    msh.delete();
    for (int i = 0; i < L; i++) msh.push_back(1'b0);
    for (int p = 0; p < NP; p++) begin
      aen[p]  = 1'b0;
      asel[p] = 0;
    end
    mcnt = 0;
    mfd  = 1'b0;
    mcv  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":top_out"}, 32'(top_out), 32'(bot_in));
    check_eq({tag, ":bot_out"}, 32'(bot_out), 32'(top_in));
    check_eq({tag, ":ipin"}, 32'(ipin), 32'(exp_ipin(MS)));
    check_eq({tag, ":ipin6"}, 32'(ipin6), 32'(exp_ipin(MS6)));
    check_eq({tag, ":tail"}, 32'(tail), 32'(msh[L-1]));
    check_eq({tag, ":frame_done"}, 32'(fd), 32'(mfd));
    check_eq({tag, ":cfg_valid"}, 32'(cv), 32'(mcv));
  endtask

  // One clock edge with the given controls; model follows the edge, then outputs are checked.
  task automatic step(input bit h, input bit e, input bit c, input string tag);
    head   = h;
    en     = e;
    commit = c;
    @(posedge prog_clk);
    mfd = e && !c && (mcnt == L - 1);
    if (c) begin
      for (int p = 0; p < NP; p++) begin
        aen[p]  = msh[p*F];
        asel[p] = 0;
        for (int b = 0; b < SW; b++) if (msh[p*F+1+b]) asel[p] += (1 << b);
      end
      mcv  = 1'b1;
      mcnt = 0;
    end else if (e) begin
      mcnt = (mcnt + 1) % L;
    end
    if (e) begin
      msh.push_front(h);
      void'(msh.pop_back());
    end
    #1;
    check_all(tag);
  endtask

  task automatic new_tracks(input string tag);
    bot_in = CW'($urandom);
    top_in = CW'($urandom);
    #1;
    check_all(tag);
  endtask

  // Shift a full frame; cfg[p*F +: F] = {sel, en} for pin p, highest bit goes in first.
  task automatic shift_frame(input logic [L-1:0] cfg, input string tag);
    for (int i = L - 1; i >= 0; i--) step(cfg[i], 1'b1, 1'b0, tag);
  endtask

  logic [L-1:0] cfg;
  logic [L-1:0] pat;

  initial begin
    pReset = 1'b1;
    bot_in = '0;
    top_in = '0;
    head   = 1'b0;
    en     = 1'b0;
    commit = 1'b0;
    model_reset();
    @(posedge prog_clk);
    #1;
    check_all("reset");
    pReset = 1'b0;
    for (int i = 0; i < 4; i++) new_tracks("pass");

    // Pin 0: enable, sel=3 -> top track 6.
    cfg = '0;
    cfg[0 +: F] = {3'd3, 1'b1};
    shift_frame(cfg, "frame0");
    check_eq("frame_done_after_28", 32'(fd), 32'd1);
    step(1'b0, 1'b0, 1'b0, "idle0");
    check_eq("frame_done_one_cycle", 32'(fd), 32'd0);
    step(1'b0, 1'b0, 1'b1, "commit0");
    check_eq("cfg_valid_set", 32'(cv), 32'd1);
    for (int i = 0; i < 4; i++) begin
      new_tracks("pin0_trk");
      check_eq("pin0_top6", 32'(ipin[0]), 32'(top_in[6]));
    end

    // Pin 2: enable, sel=7 -> wraps to top track 0; on the 6-input instance sel=7 is dead.
    cfg = '0;
    cfg[2*F +: F] = {3'd7, 1'b1};
    cfg[4*F +: F] = {3'd6, 1'b1};
    shift_frame(cfg, "frame2");
    step(1'b0, 1'b0, 1'b1, "commit2");
    for (int i = 0; i < 4; i++) begin
      new_tracks("pin2_trk");
      check_eq("pin2_top0", 32'(ipin[2]), 32'(top_in[0]));
      check_eq("mux6_sel7_zero", 32'(ipin6[2]), 32'd0);
    end

    // New frame without commit keeps routing; a bit pattern returns on the tail.
    pat = L'({$urandom, $urandom});
    pat[L-1 -: 4] = 4'b1011;
    shift_frame(pat, "pattern");
    new_tracks("nocommit");
    for (int i = L - 1; i >= L - 4; i--) begin
      check_eq("tail_pattern", 32'(tail), 32'(pat[i]));
      step(1'b0, 1'b1, 1'b0, "drain");
    end
    step(1'b0, 1'b0, 1'b1, "commit3");
    new_tracks("commit3_trk");

    // Shift + commit together at the last bit of a frame.
    for (int i = 0; i < L - 1; i++) step(1'($urandom), 1'b1, 1'b0, "pre_sim");
    step(1'($urandom), 1'b1, 1'b1, "sim");
    step(1'b0, 1'b0, 1'b0, "sim_after");
    check_eq("sim_no_frame_done", 32'(fd), 32'd0);
    for (int i = 0; i < 3; i++) new_tracks("sim_trk");

    // Asynchronous reset mid-shift with live routing.
    bot_in = '1;
    top_in = '1;
    cfg = '0;
    for (int p = 0; p < NP; p++) cfg[p*F +: F] = {3'(p), 1'b1};
    shift_frame(cfg, "live");
    step(1'b0, 1'b0, 1'b1, "live_commit");
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, 1'b0, "partial");
    #2;
    pReset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check_eq("async_ipin_zero", 32'(ipin), 32'd0);
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    check_all("reset_rel");
    cfg = L'({$urandom, $urandom});
    shift_frame(cfg, "fresh");
    step(1'b0, 1'b0, 1'b1, "fresh_commit");
    for (int i = 0; i < 3; i++) new_tracks("fresh_trk");

    // Random traffic with gaps in ccff_en and occasional commits.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0, "rand");
      if (i % 8 == 0) new_tracks("rand_trk");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
